// File: rtl/serial_adder_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder/subtractor.
package serial_adder_pkg;

    // Operation sequencing states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of digit cycles per operation; returns 0 when digit does not
    // divide width so the caller can reject the configuration at elaboration.
    function automatic int calc_ndig(input int width, input int digit);
        if ((digit > 0) && ((width % digit) == 0)) begin
            return width / digit;
        end else begin
            return 0;
        end
    endfunction

endpackage

// File: rtl/serial_add_digit.sv
// Combinational DIGIT-wide adder slice. Also exposes the carry into the top
// bit of the slice so the caller can derive signed overflow on the last digit.
module serial_add_digit #(
    parameter int DIGIT = 8
) (
    input  logic [DIGIT-1:0] a_d,
    input  logic [DIGIT-1:0] b_d,
    input  logic             c_in,
    output logic [DIGIT-1:0] d,
    output logic             c_out,
    output logic             c_msb
);

    logic [1:0] top_s;

    generate
        if (DIGIT > 1) begin : g_multi
            logic [DIGIT-1:0] low_s;

            assign low_s = {1'b0, a_d[DIGIT-2:0]}
                         + {1'b0, b_d[DIGIT-2:0]}
                         + {{(DIGIT-1){1'b0}}, c_in};
            assign c_msb = low_s[DIGIT-1];
            assign top_s = {1'b0, a_d[DIGIT-1]} + {1'b0, b_d[DIGIT-1]} + {1'b0, c_msb};
            assign d     = {top_s[0], low_s[DIGIT-2:0]};
        end else begin : g_single
            // A one-bit slice: the carry into its only bit is the incoming carry.
            assign c_msb = c_in;
            assign top_s = {1'b0, a_d[0]} + {1'b0, b_d[0]} + {1'b0, c_in};
            assign d     = top_s[0];
        end
    endgenerate

    assign c_out = top_s[1];

endmodule

// File: rtl/serial_adder_hs.sv
// Digit-serial adder/subtractor with valid/ready handshakes. Processes DIGIT
// bits per clock, LSB digit first; result is held until the next one loads.
module serial_adder_hs
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    localparam int NDIG = calc_ndig(WIDTH, DIGIT);
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    generate
        if (NDIG == 0) begin : g_bad_digit
            $error("serial_adder_hs: DIGIT must divide WIDTH");
        end
    endgenerate

    state_t           state_r;
    state_t           state_nx_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] s_r;
    logic             c_r;
    logic [CW-1:0]    cnt_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] sum_r;
    logic             carry_r;
    logic             overflow_r;

    logic [DIGIT-1:0] dig_d_s;
    logic             dig_c_s;
    logic             dig_msb_s;
    logic [WIDTH-1:0] s_nx_s;
    logic             last_s;
    logic             accept_s;

    serial_add_digit #(.DIGIT(DIGIT)) u_digit (
        .a_d   (a_r[DIGIT-1:0]),
        .b_d   (b_r[DIGIT-1:0]),
        .c_in  (c_r),
        .d     (dig_d_s),
        .c_out (dig_c_s),
        .c_msb (dig_msb_s)
    );

    // New digit enters at the top; after NDIG shifts s_r holds the full sum.
    assign s_nx_s   = (s_r >> DIGIT) | (WIDTH'(dig_d_s) << (WIDTH - DIGIT));
    assign last_s   = (cnt_r == LAST);
    assign accept_s = in_valid && in_ready_r;

    // Next-state logic for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nx_s = RUN;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = DONE;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // State register and registered handshake flags derived from next state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            in_ready_r  <= (state_nx_s == IDLE);
            out_valid_r <= (state_nx_s == DONE);
        end
    end

    // Operand capture, digit shifting and result load on the final digit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_r        <= {WIDTH{1'b0}};
            b_r        <= {WIDTH{1'b0}};
            s_r        <= {WIDTH{1'b0}};
            c_r        <= 1'b0;
            cnt_r      <= {CW{1'b0}};
            sum_r      <= {WIDTH{1'b0}};
            carry_r    <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        // Subtraction is a + ~b + 1; cin acts as a borrow-in.
                        a_r   <= a;
                        b_r   <= sub ? ~b : b;
                        c_r   <= cin ^ sub;
                        cnt_r <= {CW{1'b0}};
                    end
                end
                RUN: begin
                    a_r   <= a_r >> DIGIT;
                    b_r   <= b_r >> DIGIT;
                    s_r   <= s_nx_s;
                    c_r   <= dig_c_s;
                    cnt_r <= cnt_r + CW'(1);
                    if (last_s) begin
                        sum_r      <= s_nx_s;
                        carry_r    <= dig_c_s;
                        overflow_r <= dig_c_s ^ dig_msb_s;
                    end
                end
                DONE: begin
                    cnt_r <= {CW{1'b0}};
                end
                default: begin
                    cnt_r <= {CW{1'b0}};
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign sum       = sum_r;
    assign carry     = carry_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_serial_adder_hs.sv
// Directed, table-driven bench for serial_adder_hs at DIGIT=8, 1 and 32.
module tb_serial_adder_hs;

    logic        clock;
    logic        reset_n;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic        in_valid  [3];
    logic        in_ready  [3];
    logic        out_valid [3];
    logic        out_ready [3];
    logic [31:0] sum       [3];
    logic        carry     [3];
    logic        overflow  [3];

    int n_total;
    int n_pass;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] sum;
        logic        carry;
        logic        ovf;
    } vec_t;

    vec_t vecs [8];

    serial_adder_hs #(.WIDTH(32), .DIGIT(8)) u_d8 (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .sum(sum[0]), .carry(carry[0]), .overflow(overflow[0])
    );

    serial_adder_hs #(.WIDTH(32), .DIGIT(1)) u_d1 (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .sum(sum[1]), .carry(carry[1]), .overflow(overflow[1])
    );

    serial_adder_hs #(.WIDTH(32), .DIGIT(32)) u_d32 (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .sum(sum[2]), .carry(carry[2]), .overflow(overflow[2])
    );

    // Free-running clock, 10 time-unit period.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Issue one operation on instance k with out_ready high and check result and latency.
    task automatic run_op(input int k, input vec_t v, input int exp_lat, input string tag);
        int lat;
        lat = 1000;
        @(negedge clock);
        chk({tag, " in_ready before"}, 64'(in_ready[k]), 64'd1);
        a = v.a; b = v.b; cin = v.cin; sub = v.sub;
        in_valid[k] = 1'b1;
        @(posedge clock);
        #1;
        in_valid[k] = 1'b0;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            @(posedge clock);
            #1;
            if (out_valid[k]) begin
                lat = cyc;
                break;
            end
        end
        chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, " sum"}, 64'(sum[k]), 64'(v.sum));
        chk({tag, " carry"}, 64'(carry[k]), 64'(v.carry));
        chk({tag, " overflow"}, 64'(overflow[k]), 64'(v.ovf));
        @(posedge clock);
        #1;
        chk({tag, " out_valid drop"}, 64'(out_valid[k]), 64'd0);
        chk({tag, " in_ready back"}, 64'(in_ready[k]), 64'd1);
    endtask

    initial begin
        int lats [3];
        bit seen;
        int lat;
        vec_t v;
        n_total = 0;
        n_pass  = 0;
        lats[0] = 4; lats[1] = 32; lats[2] = 1;

        //            a             b             cin   sub   sum           carry ovf
        vecs[0] = '{32'd500,       32'd600,       1'b0, 1'b0, 32'd1100,     1'b0, 1'b0};
        vecs[1] = '{32'd1500,      32'd11600,     1'b1, 1'b0, 32'd13101,    1'b0, 1'b0};
        vecs[2] = '{32'hFFFFFFFF,  32'd1,         1'b0, 1'b0, 32'd0,        1'b1, 1'b0};
        vecs[3] = '{32'h7FFFFFFF,  32'd1,         1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vecs[4] = '{32'd600,       32'd500,       1'b0, 1'b1, 32'd100,      1'b1, 1'b0};
        vecs[5] = '{32'd500,       32'd600,       1'b0, 1'b1, 32'hFFFFFF9C, 1'b0, 1'b0};
        vecs[6] = '{32'h80000000,  32'd1,         1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
        vecs[7] = '{32'd600,       32'd500,       1'b1, 1'b1, 32'd99,       1'b1, 1'b0};

        a = 32'd0; b = 32'd0; cin = 1'b0; sub = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b1;
        end
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        // Reset state of every instance.
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst%0d in_ready", k), 64'(in_ready[k]), 64'd1);
            chk($sformatf("rst%0d out_valid", k), 64'(out_valid[k]), 64'd0);
            chk($sformatf("rst%0d sum", k), 64'(sum[k]), 64'd0);
            chk($sformatf("rst%0d carry/ovf", k), 64'({carry[k], overflow[k]}), 64'd0);
        end

        // Full table on the default configuration.
        for (int i = 0; i < 8; i++) begin
            run_op(0, vecs[i], 4, $sformatf("d8 v%0d", i));
        end
        // First four vectors on the extreme digit widths.
        for (int k = 1; k < 3; k++) begin
            for (int i = 0; i < 4; i++) begin
                run_op(k, vecs[i], lats[k], $sformatf("k%0d v%0d", k, i));
            end
        end

        // Backpressure: hold the result for 5 cycles with out_ready low.
        out_ready[0] = 1'b0;
        v = '{32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 1'b0, 1'b0};
        @(negedge clock);
        a = v.a; b = v.b; cin = v.cin; sub = v.sub;
        in_valid[0] = 1'b1;
        @(posedge clock);
        #1;
        in_valid[0] = 1'b0;
        lat = 1000;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            @(posedge clock);
            #1;
            if (out_valid[0]) begin
                lat = cyc;
                break;
            end
        end
        chk("bp latency", 64'(lat), 64'd4);
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            chk($sformatf("bp hold%0d out_valid", i), 64'(out_valid[0]), 64'd1);
            chk($sformatf("bp hold%0d sum", i), 64'(sum[0]), 64'd7);
            chk($sformatf("bp hold%0d in_ready", i), 64'(in_ready[0]), 64'd0);
        end
        @(negedge clock);
        out_ready[0] = 1'b1;
        @(posedge clock);
        #1;
        chk("bp release out_valid", 64'(out_valid[0]), 64'd0);
        chk("bp release in_ready", 64'(in_ready[0]), 64'd1);
        chk("bp sum held", 64'(sum[0]), 64'd7);

        // Reset mid-RUN: asynchronous clear, no result afterwards.
        @(negedge clock);
        a = 32'd10; b = 32'd20; cin = 1'b0; sub = 1'b0;
        in_valid[0] = 1'b1;
        @(posedge clock);
        #1;
        in_valid[0] = 1'b0;
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst sum", 64'(sum[0]), 64'd0);
        chk("arst in_ready", 64'(in_ready[0]), 64'd1);
        chk("arst out_valid", 64'(out_valid[0]), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock);
            #1;
            if (out_valid[0]) seen = 1'b1;
        end
        chk("arst no out_valid", 64'(seen), 64'd0);
        chk("arst sum stays 0", 64'(sum[0]), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
